// File: rtl/pwr_seq_pkg.sv
// Shared types, constants and mask helpers for the power-enable sequencer.
package pwr_seq_pkg;

  localparam int STEP_W      = 6;
  localparam int MAX_MODULES = 32;

  localparam logic [1:0] MODE_THERM = 2'd0;
  localparam logic [1:0] MODE_WALK  = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DWELL,
    ST_REPORT,
    ST_DONE
  } state_t;

  // Enable mask for step k; modes other than walking-one fall back to thermometer.
  function automatic logic [MAX_MODULES-1:0] mask_for(input logic [1:0]        mode,
                                                      input logic [STEP_W-1:0] k);
    logic [MAX_MODULES:0] one_hot;
    logic [MAX_MODULES:0] therm;
    one_hot = (MAX_MODULES+1)'(1) << k;
    therm   = one_hot - (MAX_MODULES+1)'(1);
    if (mode == MODE_WALK) mask_for = one_hot[MAX_MODULES-1:0];
    else                   mask_for = therm[MAX_MODULES-1:0];
  endfunction

  // Number of steps in a schedule for n enable bits.
  function automatic logic [STEP_W-1:0] num_steps(input logic [1:0] mode, input int n);
    if (mode == MODE_WALK) num_steps = STEP_W'(n);
    else                   num_steps = STEP_W'(n + 1);
  endfunction

endpackage

// File: rtl/pwr_en_sequencer_activity_counter.sv
// Registers the DUT activity vector and counts cycles in which it changed.
module activity_counter
  import pwr_seq_pkg::*;
#(
  parameter int NUM_MODULES = 32
) (
  input  logic                   clk100m,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [NUM_MODULES-1:0] dummy_in,
  output logic [15:0]            count_next
);

  logic [NUM_MODULES-1:0] dummy_q;
  logic [NUM_MODULES-1:0] dummy_q_prev;
  logic [15:0]            count;
  logic                   changed;

  assign changed = (dummy_q != dummy_q_prev);

  // Saturating next-count value, also used by the FSM to capture the final step count.
  always_comb begin
    // NOTE: default assignment first so every path drives count_next and no latch is inferred.
    count_next = count;
    if (enable && changed && (count != 16'hFFFF)) count_next = count + 16'd1;
  end

  // Two-stage capture of dummy_in plus the count register.
  always_ff @(posedge clk100m) begin
    if (rst) begin
      dummy_q      <= '0;
      dummy_q_prev <= '0;
      count        <= '0;
    end else begin
      // NOTE: non-blocking so dummy_q_prev takes the value dummy_q held before this edge.
      dummy_q      <= dummy_in;
      dummy_q_prev <= dummy_q;
      count        <= clear ? 16'd0 : count_next;
    end
  end

endmodule

// File: rtl/pwr_en_sequencer.sv
// Walks power-enable masks through a settle/dwell schedule and reports DUT activity per step.
module pwr_en_sequencer
  import pwr_seq_pkg::*;
#(
  parameter int NUM_MODULES   = 32,
  parameter int DWELL_W       = 32,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                   clk100m,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             mode,
  input  logic [DWELL_W-1:0]     dwell_cycles,
  output logic [NUM_MODULES-1:0] pwr_en_out,
  input  logic [NUM_MODULES-1:0] dummy_in,
  output logic                   busy,
  output logic                   step_valid,
  output logic [STEP_W-1:0]      step_idx,
  output logic [15:0]            toggle_count,
  output logic                   done
);

  localparam int                SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  state_t              state;
  logic [1:0]          mode_q;
  logic [DWELL_W-1:0]  dwell_q;
  logic [DWELL_W-1:0]  dwell_cnt;
  logic [SET_W-1:0]    settle_cnt;
  logic [STEP_W-1:0]   step;

  logic [MAX_MODULES-1:0] first_mask_full;
  logic [MAX_MODULES-1:0] next_mask_full;
  logic [STEP_W-1:0]      steps_total;
  logic                   last_step;
  logic                   dwell_last;
  logic [15:0]            act_next;

  assign first_mask_full = mask_for(mode, '0);
  assign next_mask_full  = mask_for(mode_q, step + STEP_W'(1));
  assign steps_total     = num_steps(mode_q, NUM_MODULES);
  assign last_step       = (step == steps_total - STEP_W'(1));
  assign dwell_last      = (dwell_cnt == dwell_q - DWELL_W'(1));

  activity_counter #(
    .NUM_MODULES (NUM_MODULES)
  ) u_activity (
    .clk100m    (clk100m),
    .rst        (rst),
    .clear      (state == ST_SETTLE),
    .enable     (state == ST_DWELL),
    .dummy_in   (dummy_in),
    .count_next (act_next)
  );

  // Schedule FSM with step/settle/dwell counters and registered outputs.
  always_ff @(posedge clk100m) begin
    if (rst) begin
      state        <= ST_IDLE;
      mode_q       <= '0;
      dwell_q      <= '0;
      dwell_cnt    <= '0;
      settle_cnt   <= '0;
      step         <= '0;
      pwr_en_out   <= '0;
      busy         <= 1'b0;
      step_valid   <= 1'b0;
      step_idx     <= '0;
      toggle_count <= '0;
      done         <= 1'b0;
    end else begin
      // Pulse outputs default low so each assertion lasts exactly one cycle.
      step_valid <= 1'b0;
      done       <= 1'b0;
      if (abort) begin
        state      <= ST_IDLE;
        busy       <= 1'b0;
        pwr_en_out <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              mode_q     <= mode;
              dwell_q    <= (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
              step       <= '0;
              settle_cnt <= '0;
              pwr_en_out <= first_mask_full[NUM_MODULES-1:0];
              busy       <= 1'b1;
              state      <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              dwell_cnt <= '0;
              state     <= ST_DWELL;
            end else begin
              settle_cnt <= settle_cnt + SET_W'(1);
            end
          end
          ST_DWELL: begin
            if (dwell_last) begin
              step_valid   <= 1'b1;
              step_idx     <= step;
              toggle_count <= act_next;
              state        <= ST_REPORT;
            end else begin
              dwell_cnt <= dwell_cnt + DWELL_W'(1);
            end
          end
          ST_REPORT: begin
            if (last_step) begin
              pwr_en_out <= '0;
              done       <= 1'b1;
              state      <= ST_DONE;
            end else begin
              step       <= step + STEP_W'(1);
              settle_cnt <= '0;
              pwr_en_out <= next_mask_full[NUM_MODULES-1:0];
              state      <= ST_SETTLE;
            end
          end
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            busy       <= 1'b0;
            pwr_en_out <= '0;
            state      <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwr_en_sequencer.sv
// Directed bench for pwr_en_sequencer: reset, full schedules, saturation, abort, busy-start.
module tb_pwr_en_sequencer;

  logic        clk100m = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic [31:0] dwell_cycles;
  logic [31:0] pwr_en_out;
  logic [31:0] dummy_in;
  logic        busy;
  logic        step_valid;
  logic [5:0]  step_idx;
  logic [15:0] toggle_count;
  logic        done;

  int checks   = 0;
  int failures = 0;

  always #5 clk100m = ~clk100m;

  pwr_en_sequencer #(
    .NUM_MODULES   (32),
    .DWELL_W       (32),
    .SETTLE_CYCLES (16)
  ) dut (
    .clk100m      (clk100m),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .mode         (mode),
    .dwell_cycles (dwell_cycles),
    .pwr_en_out   (pwr_en_out),
    .dummy_in     (dummy_in),
    .busy         (busy),
    .step_valid   (step_valid),
    .step_idx     (step_idx),
    .toggle_count (toggle_count),
    .done         (done)
  );

  // Expected enable mask for step k.
  function automatic logic [31:0] exp_mask(input logic [1:0] m, input int k);
    logic [31:0] one;
    one = 32'h1;
    if (m == 2'd1) return one << k;
    if (k >= 32)   return 32'hFFFF_FFFF;
    return (one << k) - 32'h1;
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick(input bit tog);
    if (tog) dummy_in = ~dummy_in;
    @(posedge clk100m);
    #1;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    start        = 1'b1;
    abort        = 1'b0;
    mode         = 2'd0;
    dwell_cycles = 32'd4;
    dummy_in     = 32'h0;
    repeat (4) tick(1'b1);
    checks++;
    if (busy !== 1'b0 || pwr_en_out !== 32'h0 || step_valid !== 1'b0 || done !== 1'b0 ||
        step_idx !== 6'd0 || toggle_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_hold: busy/mask/sv/done/idx/cnt got %b/%h/%b/%b/%0d/%0d expected 0/0/0/0/0/0",
               busy, pwr_en_out, step_valid, done, step_idx, toggle_count);
    end
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0);
      checks++;
      if (busy !== 1'b0 || pwr_en_out !== 32'h0 || step_valid !== 1'b0 || done !== 1'b0 ||
          step_idx !== 6'd0 || toggle_count !== 16'd0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d: busy/mask/sv/done/idx/cnt got %b/%h/%b/%b/%0d/%0d expected 0/0/0/0/0/0",
                 i, busy, pwr_en_out, step_valid, done, step_idx, toggle_count);
      end
    end
  endtask

  // Runs one schedule and checks every cycle against the spec timing.
  // abort_c > 0: abort asserted for the edge after sample c. extra_start_c > 0: stray start pulse.
  task automatic run_sched(input string name, input logic [1:0] m, input logic [31:0] d,
                           input bit tog, input int exp_cnt, input int abort_c,
                           input bit abort_with_start, input int extra_start_c);
    int          d_eff, steps, p, last_c, k, ph, sv_seen, sv_exp;
    logic [31:0] e_mask;
    logic        e_busy, e_sv, e_done;
    d_eff   = (d == 32'd0) ? 1 : int'(d);
    steps   = (m == 2'd1) ? 32 : 33;
    p       = 16 + d_eff + 1;
    last_c  = (abort_c > 0) ? abort_c + 2 : steps * p + 2;
    sv_seen = 0;
    sv_exp  = 0;
    k       = 0;
    mode         = m;
    dwell_cycles = d;
    start        = 1'b1;
    tick(tog);
    start = 1'b0;
    // Scramble the inputs to show they were latched at start.
    mode         = (m == 2'd1) ? 2'd0 : 2'd1;
    dwell_cycles = 32'd7;
    for (int c = 1; c <= last_c; c++) begin
      if (abort_c > 0 && c > abort_c) begin
        e_busy = 1'b0; e_mask = 32'h0; e_sv = 1'b0; e_done = 1'b0;
      end else if (c <= steps * p) begin
        k      = (c - 1) / p;
        ph     = (c - 1) % p;
        e_busy = 1'b1;
        e_mask = exp_mask(m, k);
        e_sv   = (ph == p - 1);
        e_done = 1'b0;
      end else if (c == steps * p + 1) begin
        e_busy = 1'b1; e_mask = 32'h0; e_sv = 1'b0; e_done = 1'b1;
      end else begin
        e_busy = 1'b0; e_mask = 32'h0; e_sv = 1'b0; e_done = 1'b0;
      end
      checks++;
      if (busy !== e_busy || pwr_en_out !== e_mask || step_valid !== e_sv || done !== e_done) begin
        failures++;
        $display("FAIL %s c=%0d: busy/mask/sv/done got %b/%h/%b/%b expected %b/%h/%b/%b",
                 name, c, busy, pwr_en_out, step_valid, done, e_busy, e_mask, e_sv, e_done);
      end
      if (step_valid === 1'b1) sv_seen++;
      if (e_sv) begin
        sv_exp++;
        checks++;
        if (step_idx !== 6'(k) || toggle_count !== 16'(exp_cnt)) begin
          failures++;
          $display("FAIL %s_report c=%0d: idx/cnt got %0d/%0d expected %0d/%0d",
                   name, c, step_idx, toggle_count, k, exp_cnt);
        end
      end
      if (c == abort_c) begin
        abort = 1'b1;
        if (abort_with_start) start = 1'b1;
      end
      if (c == extra_start_c) start = 1'b1;
      if (c < last_c) begin
        tick(tog);
        abort = 1'b0;
        start = 1'b0;
      end
    end
    checks++;
    if (sv_seen != sv_exp) begin
      failures++;
      $display("FAIL %s_pulses: step_valid pulses got %0d expected %0d", name, sv_seen, sv_exp);
    end
  endtask

  task automatic test_therm_full();
    run_sched("therm_d4", 2'd0, 32'd4, 1'b1, 4, 0, 1'b0, 0);
  endtask

  task automatic test_abort();
    // Step 5 DWELL first cycle: c = 5*21 + 17 = 122.
    run_sched("abort_d", 2'd0, 32'd4, 1'b1, 4, 122, 1'b0, 0);
    run_sched("walk_d0", 2'd1, 32'd0, 1'b0, 0, 0, 1'b0, 0);
    // Walking-one, period 18: step 5 DWELL at c = 5*18 + 17 = 107.
    run_sched("abort_st", 2'd1, 32'd0, 1'b0, 0, 107, 1'b1, 0);
    run_sched("restart", 2'd1, 32'd0, 1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic test_saturation();
    // One step of 70000 dwell cycles, then abort shortly after the report at c = 70017.
    run_sched("saturate", 2'd1, 32'd70000, 1'b1, 65535, 70019, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    // Reserved mode 2 runs the thermometer schedule; stray start mid-run is ignored.
    run_sched("busy_start", 2'd2, 32'd2, 1'b1, 2, 0, 1'b0, 40);
  endtask

  initial begin
    test_reset();
    test_therm_full();
    test_abort();
    test_saturation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
